// File: rtl/bch_pkg.sv
// Shared types and default field parameters for the iterative BCH Berlekamp-Massey solver.
package bch_pkg;

  localparam int unsigned BCH_M = 4;
  localparam int unsigned BCH_T = 2;
  localparam logic [BCH_M:0] BCH_PRIM_POLY = 5'h13;

  typedef logic [BCH_M-1:0] gf_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISC = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } bm_state_t;

endpackage

// File: rtl/bch_bm_iter_gf_mul.sv
// Combinational GF(2^M) multiplier: polynomial product reduced modulo PRIM_POLY.
module gf_mul_p #(
  parameter int unsigned M         = 4,
  parameter logic [M:0]  PRIM_POLY = 5'h13
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] prod_c
);

  logic [M-1:0] acc;

  // Horner evaluation over the bits of b, MSB first, reducing after each shift.
  always_comb begin
    acc = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? PRIM_POLY[M-1:0] : '0);
      if (b[i]) begin
        acc = acc ^ a;
      end
    end
    prod_c = acc;
  end

endmodule

// File: rtl/bch_bm_iter.sv
// Iterative inversionless Berlekamp-Massey key-equation solver for t-error BCH over GF(2^M).
// Optional uncorrectable detection is enabled by defining BCH_BM_FAIL_DETECT_EN.
module bch_bm_iter
  import bch_pkg::*;
#(
  parameter int unsigned M         = BCH_M,
  parameter int unsigned T         = BCH_T,
  parameter logic [M:0]  PRIM_POLY = BCH_PRIM_POLY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*T*M-1:0]           syn,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(T+1)*M-1:0]         lambda,
  output logic [$clog2(2*T+1)-1:0]   err_cnt,
  output logic                       fail
);

  localparam int unsigned NS = 2 * T;
  localparam int unsigned NC = T + 1;
  localparam int unsigned LW = $clog2(2 * T + 1);

  bm_state_t state_q, state_d;

  logic [M-1:0]  syn_q   [1:NS];
  logic [M-1:0]  lam_q   [NC];
  logic [M-1:0]  b_q     [NC];
  logic [M-1:0]  gamma_q;
  logic [M-1:0]  delta_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] r_q;

  logic [M-1:0]  disc_op   [NC];
  logic [M-1:0]  disc_term [NC];
  logic [M-1:0]  scaled    [NC];
  logic [M-1:0]  corr      [NC];
  logic [M-1:0]  xb        [NC];
  logic [M-1:0]  lam_upd   [NC];
  logic [M-1:0]  delta_d;

  logic          do_swap;
  logic          last_iter;
  logic [LW-1:0] len_upd;
  logic [LW-1:0] len_fin;

  logic accept, disc_en, upd_en, fin_load;
  logic in_ready_d, out_valid_d;

  // Syndrome operand per coefficient: S_(r+1-j), zero when the index falls below 1.
  always_comb begin
    for (int j = 0; j < int'(NC); j++) begin
      disc_op[j] = '0;
      for (int i = 1; i <= int'(NS); i++) begin
        if (int'(r_q) + 1 == i + j) begin
          disc_op[j] = syn_q[i];
        end
      end
    end
  end

  for (genvar j = 0; j < int'(NC); j++) begin : g_coef
    if (j == 0) begin : g_xb0
      assign xb[j] = '0;
    end else begin : g_xbn
      assign xb[j] = b_q[j-1];
    end

    gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_disc (
      .a      (lam_q[j]),
      .b      (disc_op[j]),
      .prod_c (disc_term[j])
    );

    gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_scale (
      .a      (gamma_q),
      .b      (lam_q[j]),
      .prod_c (scaled[j])
    );

    gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_corr (
      .a      (delta_q),
      .b      (xb[j]),
      .prod_c (corr[j])
    );

    assign lam_upd[j] = scaled[j] ^ corr[j];
  end

  always_comb begin
    delta_d = '0;
    for (int j = 0; j < int'(NC); j++) begin
      delta_d = delta_d ^ disc_term[j];
    end
  end

  // Length change only when the discrepancy is nonzero and 2L <= r.
  assign do_swap   = (delta_q != '0) && ({len_q, 1'b0} <= {1'b0, r_q});
  assign len_upd   = LW'(r_q + LW'(1) - len_q);
  assign len_fin   = do_swap ? len_upd : len_q;
  assign last_iter = (r_q == LW'(NS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DISC;
      DISC:    state_d = UPD;
      UPD:     state_d = last_iter ? DONE : DISC;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    disc_en     = 1'b0;
    upd_en      = 1'b0;
    fin_load    = 1'b0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE:    accept = in_valid;
      DISC:    disc_en = 1'b1;
      UPD: begin
        upd_en   = 1'b1;
        fin_load = last_iter;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= int'(NS); i++) syn_q[i] <= '0;
      for (int j = 0; j < int'(NC); j++) begin
        lam_q[j] <= '0;
        b_q[j]   <= '0;
      end
      gamma_q <= '0;
      delta_q <= '0;
      len_q   <= '0;
      r_q     <= '0;
    end else begin
      if (accept) begin
        for (int i = 1; i <= int'(NS); i++) syn_q[i] <= syn[i*M-1 -: M];
        for (int j = 0; j < int'(NC); j++) begin
          lam_q[j] <= (j == 0) ? M'(1) : '0;
          b_q[j]   <= (j == 0) ? M'(1) : '0;
        end
        gamma_q <= M'(1);
        len_q   <= '0;
        r_q     <= '0;
      end
      if (disc_en) begin
        delta_q <= delta_d;
      end
      if (upd_en) begin
        lam_q <= lam_upd;
        if (do_swap) begin
          b_q     <= lam_q;
          len_q   <= len_upd;
          gamma_q <= delta_q;
        end else begin
          b_q <= xb;
        end
        r_q <= r_q + LW'(1);
      end
    end
  end

  // Result registers are captured on the final update and held through DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lambda    <= '0;
      err_cnt   <= '0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (fin_load) begin
        for (int j = 0; j < int'(NC); j++) lambda[(j+1)*M-1 -: M] <= lam_upd[j];
        err_cnt <= len_fin;
      end
    end
  end

`ifdef BCH_BM_FAIL_DETECT_EN
  logic [LW-1:0] deg_fin;
  logic          fail_d;

  always_comb begin
    deg_fin = '0;
    for (int j = 1; j < int'(NC); j++) begin
      if (lam_upd[j] != '0) deg_fin = LW'(j);
    end
    fail_d = (len_fin > LW'(T)) || (deg_fin != len_fin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail <= 1'b0;
    end else if (fin_load) begin
      fail <= fail_d;
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule
